// File: rtl/mpg_pkg.sv
// mpg_pkg: shared definitions for the MPG sector writer.
//   SECTOR_SIZE_DEFAULT / ADDR_WIDTH_DEFAULT : default geometry of the ring buffer
//   HPS_ADDR_WIDTH                           : width of the hps_io sector buffer address
//   mpg_state_e                              : writer FSM states; the encodings are also
//                                              what debug_state reports
package mpg_pkg;

  localparam int SECTOR_SIZE_DEFAULT = 512;
  localparam int ADDR_WIDTH_DEFAULT  = 14;
  localparam int HPS_ADDR_WIDTH      = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PAD  = 3'd2,
    ST_REQ  = 3'd3,
    ST_XFER = 3'd4,
    ST_DONE = 3'd5
  } mpg_state_e;

  function automatic logic [2:0] state_code(mpg_state_e s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/mpg_sector_ram.sv
// mpg_sector_ram: simple dual-port byte RAM used as the capture ring buffer.
//   clk           : write and read clock
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : read port, data registered one cycle after raddr
// Contents are never reset so the array maps onto block RAM.
module mpg_sector_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mpg_sector_writer.sv
// mpg_sector_writer: buffers a byte stream into a ring buffer and hands it to the
// HPS one sd sector at a time through the hps_io write handshake.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, base_lba             : begin (or restart) a capture at base_lba
//   flush                       : end of stream; pad the last sector with 0x00 and write it
//   in_data/in_valid/in_ready   : input byte stream
//   sd_lba/sd_wr/sd_ack         : sector write request to the HPS
//   sd_buff_addr/sd_buff_din    : HPS reads the pending sector, one cycle latency
//   sectors_written, done       : progress and capture-complete status
// Optional build macro MPG_WRITER_DEBUG_EN adds debug_state, debug_level and
// debug_next_lba outputs; behaviour is otherwise identical.
//
// state | meaning
// IDLE  | after reset, moves to FILL on the next cycle
// FILL  | accepting bytes, waiting for a full sector or flush
// PAD   | flush pending with a partial sector: write 0x00 until aligned
// REQ   | sd_wr held high with sd_lba, waiting for sd_ack
// XFER  | HPS reading the sector; falling sd_ack retires it
// DONE  | flushed and drained; holds until the next start
module mpg_sector_writer
  import mpg_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int SECTOR_SIZE = SECTOR_SIZE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               base_lba,
  input  logic                      flush,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [31:0]               sd_lba,
  output logic                      sd_wr,
  input  logic                      sd_ack,
  input  logic [HPS_ADDR_WIDTH-1:0] sd_buff_addr,
  output logic [7:0]                sd_buff_din,
  output logic [31:0]               sectors_written,
  output logic                      done
`ifdef MPG_WRITER_DEBUG_EN
  ,
  output logic [2:0]                debug_state,
  output logic [15:0]               debug_level,
  output logic [15:0]               debug_next_lba
`endif
);

  localparam int SB_W = $clog2(SECTOR_SIZE);
  localparam int PW   = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] SECTOR_LVL = PW'(SECTOR_SIZE);
  localparam logic [PW-1:0] FULL_LVL   = {1'b1, {ADDR_WIDTH{1'b0}}};

  if (((SECTOR_SIZE & (SECTOR_SIZE - 1)) != 0) || (SECTOR_SIZE > (1 << ADDR_WIDTH)))
  begin : g_bad_cfg
    $error("mpg_sector_writer: SECTOR_SIZE must be a power of two <= 2**ADDR_WIDTH");
  end

  mpg_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          flush_q, flush_d;
  logic [31:0]   next_lba_q, next_lba_d;
  logic [31:0]   sd_lba_q, sd_lba_d;
  logic [31:0]   sectors_written_q, sectors_written_d;
  logic          sd_wr_q, sd_wr_d;
  logic          done_q, done_d;
  logic          ack_q;
  logic          rd_valid_q;

  logic [PW-1:0]         level;
  logic                  full;
  logic                  wr_aligned;
  logic                  accept;
  logic                  ram_we;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic [ADDR_WIDTH-1:0] ram_raddr;

  // Pointers carry one extra bit so a completely full ring is distinct from empty.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = (level == FULL_LVL);
  assign wr_aligned = (wr_ptr_q[SB_W-1:0] == '0);
  assign in_ready   = ((state_q == ST_FILL) || (state_q == ST_REQ) || (state_q == ST_XFER))
                      && !full && !flush_q;
  assign accept     = in_valid && in_ready;

  // HPS offsets are relative to the oldest unsent sector.
  assign ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(sd_buff_addr[SB_W-1:0]);

  if (SB_W < HPS_ADDR_WIDTH) begin : g_unused_addr
    logic unused_buff_addr;
    assign unused_buff_addr = ^sd_buff_addr[HPS_ADDR_WIDTH-1:SB_W];
  end

  always_comb begin
    state_d           = state_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    flush_d           = flush_q;
    next_lba_d        = next_lba_q;
    sd_lba_d          = sd_lba_q;
    sectors_written_d = sectors_written_q;
    sd_wr_d           = sd_wr_q;
    done_d            = done_q;
    ram_we            = 1'b0;
    ram_wdata         = in_data;

    if (flush) flush_d = 1'b1;

    // Byte acceptance is independent of the retire step below, so both can land
    // in the same cycle without losing either.
    if (accept) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
        if (level >= SECTOR_LVL) begin
          state_d  = ST_REQ;
          sd_lba_d = next_lba_q;
          sd_wr_d  = 1'b1;
        end else if (flush_q && !wr_aligned) begin
          state_d = ST_PAD;
        end else if (flush_q && (level == '0)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_PAD: begin
        ram_we    = 1'b1;
        ram_wdata = 8'h00;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        if (&wr_ptr_q[SB_W-1:0]) state_d = ST_FILL;
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (ack_q && !sd_ack) begin
          rd_ptr_d          = rd_ptr_q + SECTOR_LVL;
          next_lba_d        = next_lba_q + 32'd1;
          sectors_written_d = sectors_written_q + 32'd1;
          state_d           = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // A restart wins over everything, including an in-flight transfer; landing in
    // FILL means a late sd_ack fall from the aborted sector is never seen in XFER.
    if (start) begin
      state_d           = ST_FILL;
      wr_ptr_d          = '0;
      rd_ptr_d          = '0;
      flush_d           = 1'b0;
      next_lba_d        = base_lba;
      sectors_written_d = '0;
      sd_wr_d           = 1'b0;
      done_d            = 1'b0;
      ram_we            = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      flush_q           <= 1'b0;
      next_lba_q        <= '0;
      sd_lba_q          <= '0;
      sectors_written_q <= '0;
      sd_wr_q           <= 1'b0;
      done_q            <= 1'b0;
      ack_q             <= 1'b0;
      rd_valid_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      flush_q           <= flush_d;
      next_lba_q        <= next_lba_d;
      sd_lba_q          <= sd_lba_d;
      sectors_written_q <= sectors_written_d;
      sd_wr_q           <= sd_wr_d;
      done_q            <= done_d;
      ack_q             <= sd_ack;
      rd_valid_q        <= 1'b1;
    end
  end

  mpg_sector_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // The RAM read register is not reset; mask it until a read has completed
  // out of reset so sd_buff_din reads zero during reset.
  assign sd_buff_din     = rd_valid_q ? ram_rdata : 8'h00;
  assign sd_lba          = sd_lba_q;
  assign sd_wr           = sd_wr_q;
  assign sectors_written = sectors_written_q;
  assign done            = done_q;

`ifdef MPG_WRITER_DEBUG_EN
  assign debug_state    = state_code(state_q);
  assign debug_level    = 16'(level);
  assign debug_next_lba = next_lba_q[15:0];
`endif

endmodule

// File: tb/tb_mpg_sector_writer.sv
// tb_mpg_sector_writer: directed scenarios against mpg_sector_writer with an HPS
// model that pops expected sectors from a queue and checks LBA and readback data.
module tb_mpg_sector_writer;

  localparam int SS = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_lba = '0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sd_lba;
  logic        sd_wr;
  logic        sd_ack;
  logic [13:0] sd_buff_addr = '0;
  logic [7:0]  sd_buff_din;
  logic [31:0] sectors_written;
  logic        done;

  logic hps_ack = 1'b0;
  logic man_ack = 1'b0;
  assign sd_ack = hps_ack | man_ack;

  int n_checks = 0;
  int n_err = 0;
  int hps_allow = 0;
  int wr_seen = 0;

  typedef struct {
    logic [31:0] lba;
    int          first;
    int          nvalid;
    bit          mode;
  } sec_t;
  sec_t exp_q[$];

  always #5 clk = ~clk;

  mpg_sector_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_lba       (base_lba),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sd_lba         (sd_lba),
    .sd_wr          (sd_wr),
    .sd_ack         (sd_ack),
    .sd_buff_addr   (sd_buff_addr),
    .sd_buff_din    (sd_buff_din),
    .sectors_written(sectors_written),
    .done           (done)
  );

  function automatic logic [7:0] pat(int idx, bit mode);
    logic [31:0] v;
    v = idx;
    return mode ? (v[7:0] ^ v[15:8] ^ 8'h5A) : v[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(sec_t r, int j);
    return (j < r.nvalid) ? pat(r.first + j, r.mode) : 8'h00;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add_exp(logic [31:0] lba, int first, int nvalid, bit mode);
    sec_t r;
    r.lba = lba; r.first = first; r.nvalid = nvalid; r.mode = mode;
    exp_q.push_back(r);
  endtask

  // HPS model: services requests while allowed, checks LBA, ack timing and data.
  initial begin : hps_model
    sec_t r;
    int bad;
    int first_bad;
    logic [7:0] got_b, exp_b;
    forever begin
      @(negedge clk);
      if (sd_wr === 1'b1) wr_seen++;
      if (sd_wr === 1'b1 && hps_allow != 0 && !hps_ack) begin
        if (hps_allow > 0) hps_allow--;
        if (exp_q.size() == 0) begin
          chk("unexpected_sd_wr", 32'd1, 32'd0);
          r.lba = '0; r.first = 0; r.nvalid = 0; r.mode = 1'b0;
        end else begin
          r = exp_q.pop_front();
          chk("sd_lba", sd_lba, r.lba);
        end
        bad = 0; first_bad = 0; got_b = '0; exp_b = '0;
        hps_ack = 1'b1;
        sd_buff_addr = '0;
        for (int j = 0; j < SS; j++) begin
          @(negedge clk);
          if (j == 0) chk("sd_wr_after_ack", 32'(sd_wr), 32'd0);
          if (sd_buff_din !== exp_byte(r, j)) begin
            if (bad == 0) begin
              first_bad = j; got_b = sd_buff_din; exp_b = exp_byte(r, j);
            end
            bad++;
          end
          sd_buff_addr = 14'(j + 1);
        end
        hps_ack = 1'b0;
        chk("sector_data_bad_bytes", 32'(bad), 32'd0);
        if (bad != 0)
          $display("  lba %0d first bad byte %0d: got %02h expected %02h", r.lba, first_bad, got_b, exp_b);
      end
    end
  end

  task automatic do_start(logic [31:0] b);
    base_lba = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_bytes(int first, int n, bit mode);
    int i = 0;
    int idle = 0;
    while (i < n) begin
      in_valid = 1'b1;
      in_data = pat(first + i, mode);
      if (in_ready) begin i++; idle = 0; end
      else idle++;
      @(negedge clk);
      if (idle > 3000) begin
        chk("push_timeout_bytes", 32'(i), 32'(n));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sw(logic [31:0] target, int budget, string name);
    int c = 0;
    while (sectors_written !== target && c < budget) begin @(negedge clk); c++; end
    chk(name, sectors_written, target);
  endtask

  task automatic wait_done(int budget, string name);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    int c;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sectors_written", sectors_written, 32'd0);
    chk("rst_sd_buff_din", 32'(sd_buff_din), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Two sectors of 0..255 repeating at LBA 100
    hps_allow = -1;
    do_start(32'd100);
    add_exp(32'd100, 0, SS, 1'b0);
    add_exp(32'd101, SS, SS, 1'b0);
    push_bytes(0, 2 * SS, 1'b0);
    wait_sw(32'd2, 3000, "t030_sectors_written");
    chk("t030_queue_empty", 32'(exp_q.size()), 32'd0);

    // 700 bytes then flush: second sector padded from byte 188
    do_start(32'd300);
    add_exp(32'd300, 0, SS, 1'b1);
    add_exp(32'd301, SS, 188, 1'b1);
    push_bytes(0, 700, 1'b1);
    pulse_flush();
    wait_done(4000, "t031_done");
    chk("t031_sectors_written", sectors_written, 32'd2);
    chk("t031_in_ready_done", 32'(in_ready), 32'd0);
    chk("t031_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with an empty buffer: done two cycles later, no sd_wr
    do_start(32'd400);
    chk("t033_done_cleared", 32'(done), 32'd0);
    n0 = wr_seen;
    pulse_flush();
    chk("t033_done_after_1", 32'(done), 32'd0);
    @(negedge clk);
    chk("t033_done_after_2", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    chk("t033_no_sd_wr", 32'(wr_seen - n0), 32'd0);
    chk("t033_in_ready", 32'(in_ready), 32'd0);
    chk("t033_sectors_written", sectors_written, 32'd0);

    // HPS stalled: fill the whole ring, then release one sector
    hps_allow = 0;
    do_start(32'd200);
    add_exp(32'd200, 0, SS, 1'b1);
    push_bytes(0, 16384, 1'b1);
    chk("t032_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    chk("t032_still_full", 32'(in_ready), 32'd0);
    hps_allow = 1;
    c = 0;
    while (sectors_written !== 32'd1 && c < 2000) begin @(negedge clk); c++; end
    chk("t032_one_sector", sectors_written, 32'd1);
    chk("t032_ready_after_ack", 32'(in_ready), 32'd1);
    push_bytes(16384, SS, 1'b1);
    chk("t032_refull_in_ready", 32'(in_ready), 32'd0);
    chk("t032_queue_empty", 32'(exp_q.size()), 32'd0);

    // Restart in the middle of a transfer
    do_start(32'd50);
    chk("t034_abort_req", 32'(sd_wr), 32'd0);
    push_bytes(0, SS, 1'b1);
    c = 0;
    while (sd_wr !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    chk("t034_req_sd_wr", 32'(sd_wr), 32'd1);
    chk("t034_req_lba", sd_lba, 32'd50);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("t034_xfer_sd_wr", 32'(sd_wr), 32'd0);
    do_start(32'd5);
    chk("t034_start_sd_wr", 32'(sd_wr), 32'd0);
    chk("t034_start_sectors", sectors_written, 32'd0);
    man_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t034_stale_fall_sectors", sectors_written, 32'd0);
    chk("t034_stale_fall_sd_wr", 32'(sd_wr), 32'd0);
    add_exp(32'd5, 1000, SS, 1'b1);
    hps_allow = -1;
    push_bytes(1000, SS, 1'b1);
    wait_sw(32'd1, 3000, "t034_sectors_written");
    chk("t034_queue_empty", 32'(exp_q.size()), 32'd0);

    // 40 sectors back to back: ring wraps, LBAs sequential
    do_start(32'd1000);
    for (int k = 0; k < 40; k++) add_exp(32'd1000 + 32'(k), k * SS, SS, 1'b1);
    push_bytes(0, 40 * SS, 1'b1);
    wait_sw(32'd40, 4000, "t035_sectors_written");
    chk("t035_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
